// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C target peripheral.
//   state_e      : protocol FSM states
//   Reg*         : CPU register offsets, decoded on addr_i[19:16]
//   Ctrl*/Stat*  : bit positions inside CTRL and STATUS
package i2c_pkg;

  typedef enum logic [3:0] {
    StIdle,
    StAddr,
    StAddrAck,
    StPtr,
    StPtrAck,
    StWdata,
    StWdataAck,
    StRdata,
    StMack
  } state_e;

  localparam logic [3:0] RegOwnAddr = 4'h1;
  localparam logic [3:0] RegCtrl    = 4'h2;
  localparam logic [3:0] RegStatus  = 4'h3;
  localparam logic [3:0] RegData    = 4'h4;

  localparam int unsigned CtrlEnBit     = 0;
  localparam int unsigned CtrlIrqEnBit  = 1;
  localparam int unsigned StatBusyBit   = 0;
  localparam int unsigned StatWrDoneBit = 1;
  localparam int unsigned StatRdDoneBit = 2;

endpackage

// File: rtl/i2c_line_sync.sv
// SCL/SDA input conditioning: SYNC_STAGES-deep synchronizers followed by one
// delay flop used for edge detection.
//   clk, rst_n    : system clock, async active-low reset
//   i_scl, i_sda  : raw pad inputs
//   o_sda         : synchronized SDA level
//   o_scl_rise/o_scl_fall : single-cycle SCL edge strobes
//   o_start/o_stop : SDA fall/rise while SCL is high
module i2c_line_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_scl,
  input  logic i_sda,
  output logic o_sda,
  output logic o_scl_rise,
  output logic o_scl_fall,
  output logic o_start,
  output logic o_stop
);

  logic [SYNC_STAGES-1:0] r_scl_sync;
  logic [SYNC_STAGES-1:0] r_sda_sync;
  logic                   r_scl_d;
  logic                   r_sda_d;
  logic                   w_scl;
  logic                   w_sda;

  // Reset to the idle-bus level so no edge is seen coming out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scl_sync <= '1;
      r_sda_sync <= '1;
      r_scl_d    <= 1'b1;
      r_sda_d    <= 1'b1;
    end else begin
      r_scl_sync <= {r_scl_sync[SYNC_STAGES-2:0], i_scl};
      r_sda_sync <= {r_sda_sync[SYNC_STAGES-2:0], i_sda};
      r_scl_d    <= w_scl;
      r_sda_d    <= w_sda;
    end
  end

  assign w_scl      = r_scl_sync[SYNC_STAGES-1];
  assign w_sda      = r_sda_sync[SYNC_STAGES-1];
  assign o_sda      = w_sda;
  assign o_scl_rise = w_scl & ~r_scl_d;
  assign o_scl_fall = ~w_scl & r_scl_d;
  assign o_start    = w_scl & r_scl_d & ~w_sda & r_sda_d;
  assign o_stop     = w_scl & r_scl_d & w_sda & ~r_sda_d;

endmodule

// File: rtl/i2c_target.sv
// I2C target with an 8-byte register file, LM75-style pointer protocol.
//   clk, rst_n          : system clock, async active-low reset
//   we_i, addr_i, data_i, req_i, data_o : RIB CPU port (data_o combinational)
//   scl_in, sda_in      : I2C pad inputs
//   sda_out, sda_ctrl   : SDA drive value / output enable
//   irq_o               : level interrupt on wr_done | rd_done when enabled
module i2c_target
  import i2c_pkg::*;
#(
  parameter logic [6:0]  DEF_ADDR    = 7'h48,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  output logic [31:0] data_o,
  input  logic        req_i,
  input  logic        scl_in,
  input  logic        sda_in,
  output logic        sda_out,
  output logic        sda_ctrl,
  output logic        irq_o
);

  logic       w_sda, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0] r_regs [8];
  logic [6:0] r_own_addr;
  logic [1:0] r_ctrl;
  logic       r_wr_done, r_rd_done, r_irq;
  state_e     r_state, w_state_d;
  logic [2:0] r_cnt, w_cnt_d, r_ptr, w_ptr_d;
  logic [7:0] r_shift, w_shift_d, w_byte;
  logic       r_phase, w_phase_d, r_rw, w_rw_d, r_wrote, w_wrote_d;
  logic       r_sda_out, w_sda_out_d, r_sda_ctrl, w_sda_ctrl_d;
  logic       w_commit, w_set_wr, w_set_rd;
  logic       w_cpu_wr, w_clr_wr, w_clr_rd;
  logic [3:0] w_sel;
  logic [2:0] w_idx, w_status;
  logic       w_unused;

  i2c_line_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_line_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_scl     (scl_in),
    .i_sda     (sda_in),
    .o_sda     (w_sda),
    .o_scl_rise(w_scl_rise),
    .o_scl_fall(w_scl_fall),
    .o_start   (w_start),
    .o_stop    (w_stop)
  );

  assign w_byte   = {r_shift[6:0], w_sda};
  assign w_cpu_wr = req_i & we_i;
  assign w_sel    = addr_i[19:16];
  assign w_idx    = addr_i[4:2];
  assign w_clr_wr = w_cpu_wr && (w_sel == RegStatus) && data_i[StatWrDoneBit];
  assign w_clr_rd = w_cpu_wr && (w_sel == RegStatus) && data_i[StatRdDoneBit];
  assign w_unused = ^{addr_i[31:20], addr_i[15:5], addr_i[1:0], data_i[31:8]};

  // r_phase in ACK states: 0 = waiting for the fall that starts the ACK,
  // 1 = ACK on the line. In RDATA: 1 = a data bit is already on the line.
  always_comb begin
    w_state_d    = r_state;
    w_cnt_d      = r_cnt;
    w_shift_d    = r_shift;
    w_ptr_d      = r_ptr;
    w_phase_d    = r_phase;
    w_rw_d       = r_rw;
    w_wrote_d    = r_wrote;
    w_sda_out_d  = r_sda_out;
    w_sda_ctrl_d = r_sda_ctrl;
    w_commit     = 1'b0;
    w_set_wr     = 1'b0;
    w_set_rd     = 1'b0;
    if (w_stop) begin
      w_state_d    = StIdle;
      w_sda_out_d  = 1'b1;
      w_sda_ctrl_d = 1'b0;
      w_set_wr     = r_wrote;
      w_wrote_d    = 1'b0;
    end else if (!r_ctrl[CtrlEnBit]) begin
      w_state_d    = StIdle;
      w_sda_out_d  = 1'b1;
      w_sda_ctrl_d = 1'b0;
    end else if (w_start) begin
      if (r_state == StIdle) w_wrote_d = 1'b0;
      w_state_d    = StAddr;
      w_cnt_d      = 3'd0;
      w_phase_d    = 1'b0;
      w_sda_out_d  = 1'b1;
      w_sda_ctrl_d = 1'b0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StAddr, StPtr, StWdata: begin
          if (w_scl_rise) begin
            w_shift_d = w_byte;
            w_cnt_d   = r_cnt + 3'd1;
            w_phase_d = 1'b0;
            if (r_cnt == 3'd7) begin
              if (r_state == StAddr) begin
                if (w_byte[7:1] == r_own_addr) begin
                  w_state_d = StAddrAck;
                  w_rw_d    = w_byte[0];
                end else begin
                  w_state_d = StIdle;
                end
              end else if (r_state == StPtr) begin
                w_ptr_d   = w_byte[2:0];
                w_state_d = StPtrAck;
              end else begin
                w_commit  = 1'b1;
                w_ptr_d   = r_ptr + 3'd1;
                w_wrote_d = 1'b1;
                w_state_d = StWdataAck;
              end
            end
          end
        end
        StAddrAck, StPtrAck, StWdataAck: begin
          if (w_scl_fall) begin
            if (!r_phase) begin
              w_sda_ctrl_d = 1'b1;
              w_sda_out_d  = 1'b0;
              w_phase_d    = 1'b1;
            end else begin
              w_sda_ctrl_d = 1'b0;
              w_sda_out_d  = 1'b1;
              w_phase_d    = 1'b0;
              w_cnt_d      = 3'd0;
              if (r_state == StAddrAck && r_rw) begin
                // The fall that ends the ACK also launches the first read bit.
                w_state_d    = StRdata;
                w_sda_ctrl_d = 1'b1;
                w_sda_out_d  = r_regs[r_ptr][7];
                w_shift_d    = {r_regs[r_ptr][6:0], 1'b0};
                w_phase_d    = 1'b1;
              end else if (r_state == StAddrAck) begin
                w_state_d = StPtr;
              end else begin
                w_state_d = StWdata;
              end
            end
          end
        end
        StRdata: begin
          if (w_scl_fall) begin
            if (r_phase && r_cnt == 3'd7) begin
              w_sda_ctrl_d = 1'b0;
              w_sda_out_d  = 1'b1;
              w_state_d    = StMack;
            end else begin
              w_sda_ctrl_d = 1'b1;
              w_sda_out_d  = r_shift[7];
              w_shift_d    = {r_shift[6:0], 1'b0};
              w_phase_d    = 1'b1;
              if (r_phase) w_cnt_d = r_cnt + 3'd1;
            end
          end
        end
        StMack: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_ptr_d   = r_ptr + 3'd1;
              w_shift_d = r_regs[r_ptr + 3'd1];
              w_cnt_d   = 3'd0;
              w_phase_d = 1'b0;
              w_state_d = StRdata;
            end else begin
              w_state_d = StIdle;
              w_set_rd  = 1'b1;
            end
          end
        end
        default: w_state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= StIdle;
      r_cnt      <= 3'd0;
      r_shift    <= 8'd0;
      r_ptr      <= 3'd0;
      r_phase    <= 1'b0;
      r_rw       <= 1'b0;
      r_wrote    <= 1'b0;
      r_sda_out  <= 1'b1;
      r_sda_ctrl <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_cnt      <= w_cnt_d;
      r_shift    <= w_shift_d;
      r_ptr      <= w_ptr_d;
      r_phase    <= w_phase_d;
      r_rw       <= w_rw_d;
      r_wrote    <= w_wrote_d;
      r_sda_out  <= w_sda_out_d;
      r_sda_ctrl <= w_sda_ctrl_d;
    end
  end

  // CPU registers; the I2C commit is assigned last so it wins an index clash.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) r_regs[i] <= 8'd0;
      r_own_addr <= DEF_ADDR;
      r_ctrl     <= 2'd0;
      r_wr_done  <= 1'b0;
      r_rd_done  <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      if (w_cpu_wr && w_sel == RegOwnAddr) r_own_addr <= data_i[6:0];
      if (w_cpu_wr && w_sel == RegCtrl)    r_ctrl     <= data_i[1:0];
      if (w_cpu_wr && w_sel == RegData)    r_regs[w_idx] <= data_i[7:0];
      if (w_commit)                        r_regs[r_ptr] <= w_byte;
      r_wr_done <= w_set_wr | (r_wr_done & ~w_clr_wr);
      r_rd_done <= w_set_rd | (r_rd_done & ~w_clr_rd);
      r_irq     <= r_ctrl[CtrlIrqEnBit] & (r_wr_done | r_rd_done);
    end
  end

  always_comb begin
    w_status                = 3'd0;
    w_status[StatBusyBit]   = (r_state != StIdle);
    w_status[StatWrDoneBit] = r_wr_done;
    w_status[StatRdDoneBit] = r_rd_done;
  end

  always_comb begin
    data_o = 32'd0;
    if (rst_n) begin
      case (w_sel)
        RegOwnAddr: data_o = {25'd0, r_own_addr};
        RegCtrl:    data_o = {30'd0, r_ctrl};
        RegStatus:  data_o = {29'd0, w_status};
        RegData:    data_o = {24'd0, r_regs[w_idx]};
        default:    data_o = 32'd0;
      endcase
    end
  end

  assign sda_out  = r_sda_out;
  assign sda_ctrl = r_sda_ctrl;
  assign irq_o    = r_irq;

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- I2C target (slave) peripheral on the RIB bus: responds to an external I2C controller at a programmable 7-bit address.
- Exposes an 8-byte register file, readable and writable from both the I2C side and the CPU.
- Pointer-based protocol, LM75-compatible: after reset, a 2-byte controller read at address 0x48 returns reg[0], reg[1].
- Sits beside the i2c controller peripheral in the perips set; the two can be looped back against each other in simulation.

Parameters:
- DEF_ADDR, 7'h48, reset value of the own-address register.
- SYNC_STAGES, 2, synchronizer depth on scl_in/sda_in (legal values 2..3).

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- we_i  input  1  RIB write enable
- addr_i  input  32  RIB address
- data_i  input  32  RIB write data
- data_o  output  32  RIB read data (combinational)
- req_i  input  1  RIB request
- scl_in  input  1  I2C clock from pad
- sda_in  input  1  I2C data from pad
- sda_out  output  1  SDA drive value
- sda_ctrl  output  1  SDA output enable (1 = drive sda_out)
- irq_o  output  1  level interrupt

Behaviour:
- Reset: one clock; asynchronous, active-low reset (rst_n), released synchronously by flop behaviour.
- Reset values: sda_out=1, sda_ctrl=0, irq_o=0, state IDLE, ptr=0, regfile all 0, own_addr=DEF_ADDR, ctrl=0, status=0.
- Register map, CPU side, decoded on addr_i[19:16]:
  - 0x1 OWN_ADDR [6:0].
  - 0x2 CTRL: [0] enable, [1] irq enable.
  - 0x3 STATUS: [0] busy, read-only; [1] wr_done, sticky, write-1-to-clear; [2] rd_done, sticky, W1C.
  - 0x4 DATA: byte reg[addr_i[4:2]] in [7:0].
  - Other addresses read 0; writes ignored. data_o=0 while rst_n low.
- Input conditioning: scl_in/sda_in pass through SYNC_STAGES flops, then one more flop for edge detect.
  - Events: scl_rise, scl_fall, start (sda fall while scl high), stop (sda rise while scl high).
  - clk must be ≥10× SCL frequency.
- Bit timing:
  - Sample SDA on scl_rise.
  - Change sda_out/sda_ctrl one clk after scl_fall.
  - Released line: sda_ctrl=0, sda_out=1.
- FSM states: IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WDATA_ACK, RDATA, MACK.
  - Bit counter 0..7, MSB first; shift register 8 bits.
- Transitions:
  - IDLE: on start with enable=1 -> ADDR, cnt=0.
  - ADDR: after 8 bits, compare [7:1] with OWN_ADDR.
    - Match -> ADDR_ACK: drive 0 for one SCL period, released at the next scl_fall.
    - Mismatch -> IDLE, line never driven.
  - ADDR_ACK exit: R/W=0 -> PTR; R/W=1 -> RDATA, loading shift register from reg[ptr].
  - PTR: 8 bits, then ptr<=byte[2:0] -> PTR_ACK -> WDATA.
  - WDATA: 8 bits, then reg[ptr]<=byte, ptr<=ptr+1 (wraps 7->0) -> WDATA_ACK -> WDATA.
  - RDATA: drive bits MSB first, then release -> MACK.
  - MACK: sample on scl_rise.
    - 0 -> ptr<=ptr+1 (wrap), load reg[ptr+1] -> RDATA.
    - 1 -> IDLE, waiting for stop; rd_done<=1.
- Global rules:
  - stop in any state -> IDLE, line released. wr_done<=1 if at least one data byte was written in the transaction.
  - start (repeated) in any non-IDLE state -> ADDR; ptr retained.
  - enable cleared mid-transaction -> IDLE immediately, line released.
  - busy = state != IDLE.
  - CPU DATA write in the same clk as an I2C data-byte commit to the same index: I2C wins.
  - W1C write in the same clk as a set event: set wins.
  - irq_o = ctrl[1] & (wr_done | rd_done), registered (one clk after the flag sets).
- No clock stretching; SCL is input only.

Decomposition:
- Shared package i2c_pkg holds:
  - state encodings;
  - register offsets (OWN_ADDR=4'h1, CTRL=4'h2, STATUS=4'h3, DATA=4'h4);
  - bit positions of CTRL/STATUS.
- One sub-module, i2c_line_sync: synchronizers plus edge/start/stop event detect. The rest stays in i2c_target.

Test Plan:
- Reset, then controller reads 2 bytes from 0x91 with reg[0]=0x19 and reg[1]=0x80 preloaded via CPU -> target ACKs address; bytes 0x19, 0x80 on SDA; controller NACK; rd_done=1.
- Controller writes to 0x90: ptr 0x06, then data 0xAA, 0xBB, 0xCC, then stop -> reg[6]=0xAA, reg[7]=0xBB, reg[0]=0xCC (wrap); wr_done=1; irq_o=1 when CTRL=0x3.
- Address 0x4A with OWN_ADDR=0x48 -> sda_ctrl stays 0 throughout; state returns to IDLE; no flags set.
- Write ptr 0x03, then repeated start to 0x91, read 1 byte, NACK -> returns reg[3]; ptr=3; only rd_done sets.
- Stop injected mid-byte in WDATA after 4 bits -> no regfile change; IDLE; line released within 2 clk.
- CPU W1C of STATUS in the same clk as stop completing a write -> wr_done reads 1; a subsequent W1C clears it and drops irq_o.
